// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU load/store
// path (requester 0) and the UART debug/loader (requester 1). Registered
// round-robin arbitration, one access per two cycles, one-cycle read return,
// and a debug-side lock for uninterrupted bursts.
// Optional lock watchdog: define DMEM_ARB_LOCK_TIMEOUT_EN.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0,
    input  logic            req1,
    input  logic            we0,
    input  logic            we1,
    input  logic [DW/8-1:0] be0,
    input  logic [DW/8-1:0] be1,
    input  logic [AW-1:0]   addr0,
    input  logic [AW-1:0]   addr1,
    input  logic [DW-1:0]   wdata0,
    input  logic [DW-1:0]   wdata1,
    input  logic            lock1,
    output logic            gnt0,
    output logic            gnt1,
    output logic            rvalid0,
    output logic            rvalid1,
    output logic [DW-1:0]   rdata0,
    output logic [DW-1:0]   rdata1,
    output logic            mem_en,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    output logic            lock_err
);
    localparam int BW = DW / 8;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          lock_q, lock_d;
    logic          we_q, we_d;
    logic [BW-1:0] be_q, be_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          lock_eff;
    logic          arb_valid;
    logic          arb_pick;

`ifdef DMEM_ARB_LOCK_TIMEOUT_EN
    localparam int CW = $clog2(LOCK_MAX + 1);

    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          lock_err_q, lock_err_d;
    logic          timeout;

    // Watchdog: count cycles while locked and force the lock open at LOCK_MAX.
    always_comb begin
        timeout    = lock_q && (lock_cnt_q == CW'(LOCK_MAX - 1));
        lock_err_d = lock_err_q | timeout;
        if (!lock_q || timeout) begin
            lock_cnt_d = '0;
        end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
        end
    end

    // Watchdog registers; lock_err is sticky until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_cnt_q <= '0;
            lock_err_q <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            lock_err_q <= lock_err_d;
        end
    end

    assign lock_eff = lock_q & ~timeout;
    assign lock_err = lock_err_q;
`else
    assign lock_eff = lock_q;
    assign lock_err = 1'b0;
`endif

    // Pick a winner: lock restricts to requester 1, otherwise alternate on contention.
    always_comb begin
        arb_valid = 1'b0;
        arb_pick  = 1'b0;
        if (lock_eff) begin
            arb_valid = req1;
            arb_pick  = 1'b1;
        end else if (req0 && req1) begin
            arb_valid = 1'b1;
            arb_pick  = ~last_q;
        end else begin
            arb_valid = req0 | req1;
            arb_pick  = req1;
        end
    end

    // Next state: capture the winner's command in IDLE/RESP, return data in RESP.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        lock_d   = lock_eff;
        we_d     = we_q;
        be_d     = be_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        if (state_q == RESP) begin
            if (owner_q) begin
                rdata1_d = mem_rdata;
            end else begin
                rdata0_d = mem_rdata;
            end
        end

        case (state_q)
            ACCESS: state_d = RESP;
            default: begin
                if (arb_valid) begin
                    state_d = ACCESS;
                    owner_d = arb_pick;
                    last_d  = arb_pick;
                    if (arb_pick) begin
                        we_d    = we1;
                        be_d    = be1;
                        addr_d  = addr1;
                        wdata_d = wdata1;
                        lock_d  = lock1;
                    end else begin
                        we_d    = we0;
                        be_d    = be0;
                        addr_d  = addr0;
                        wdata_d = wdata0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State and command registers; round-robin starts favouring requester 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            lock_q   <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            lock_q   <= lock_d;
            we_q     <= we_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Outputs decoded from state: memory strobes and gnt in ACCESS, rvalid in RESP.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        rvalid0   = 1'b0;
        rvalid1   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        rdata0    = rdata0_d;
        rdata1    = rdata1_d;
        if (state_q == ACCESS) begin
            mem_en    = 1'b1;
            mem_we    = we_q;
            mem_be    = be_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            gnt0      = ~owner_q;
            gnt1      = owner_q;
        end
        if (state_q == RESP) begin
            rvalid0 = ~owner_q;
            rvalid1 = owner_q;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model of the arbitration rules.
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, we0, we1, lock1;
    logic [BW-1:0] be0, be1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_en, mem_we;
    logic [BW-1:0] mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          lock_err;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] env_mem [64];
    logic [DW-1:0] ref_mem [64];
    logic          model_last;
    logic          model_lock;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .be0(be0), .be1(be1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .lock_err(lock_err)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        return (i == 4) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i));
    endfunction

    // Behavioural single-port memory with one-cycle read latency.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) env_mem[i] <= init_word(i);
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < BW; b++)
                    if (mem_be[b]) env_mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= env_mem[mem_addr[7:2]];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        model_last = 1'b1;
        model_lock = 1'b0;
    endtask

    task automatic ref_write(input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] d);
        logic [5:0] idx;
        idx = a[7:2];
        for (int b = 0; b < BW; b++)
            if (be[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic test_reset();
        ref_reset();
        repeat (3) tick();
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, lock_err} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0", {gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, lock_err});
        end
        checks++;
        if ({mem_be, mem_addr, mem_wdata, rdata0, rdata1} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h expected 0", {mem_be, mem_addr, mem_wdata, rdata0, rdata1});
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mem_en} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got %b expected 0", {gnt0, gnt1, rvalid0, rvalid1, mem_en});
        end
    endtask

    task automatic test_single_read();
        req0 = 1'b1; we0 = 1'b0; be0 = '1; addr0 = 32'h10; wdata0 = '0;
        checks++;
        if (mem_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_t0_mem_en: got %b expected 0", mem_en);
        end
        tick();
        checks++;
        if ({gnt0, gnt1, mem_en, mem_we, mem_addr} !== {4'b1010, 32'h10}) begin
            errors++;
            $display("[TB] FAIL read_t1_access: got %h expected %h", {gnt0, gnt1, mem_en, mem_we, mem_addr}, {4'b1010, 32'h10});
        end
        req0 = 1'b0;
        tick();
        checks++;
        if ({rvalid0, rvalid1, gnt0, mem_en} !== 4'b1000 || rdata0 !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL read_t2_resp: got %b/%h expected 1000/deadbeef", {rvalid0, rvalid1, gnt0, mem_en}, rdata0);
        end
        model_last = 1'b0;
        tick();
        checks++;
        if (rvalid0 !== 1'b0 || rdata0 !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL read_t3_hold: got %b/%h expected 0/deadbeef", rvalid0, rdata0);
        end
    endtask

    task automatic test_single_write();
        req1 = 1'b1; we1 = 1'b1; be1 = 4'h3; addr1 = 32'h8; wdata1 = 32'h0000A5A5; lock1 = 1'b0;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL write_gnt: got %b expected 01", {gnt0, gnt1});
        end
        checks++;
        if ({mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'h3, 32'h8, 32'h0000A5A5}) begin
            errors++;
            $display("[TB] FAIL write_mem_cmd: got %h expected %h", {mem_en, mem_we, mem_be, mem_addr, mem_wdata},
                     {1'b1, 1'b1, 4'h3, 32'h8, 32'h0000A5A5});
        end
        ref_write(32'h8, 4'h3, 32'h0000A5A5);
        req1 = 1'b0;
        tick();
        checks++;
        if ({rvalid0, rvalid1, gnt0, gnt1} !== 4'b0100 || rdata0 !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL write_resp: got %b/%h expected 0100/deadbeef", {rvalid0, rvalid1, gnt0, gnt1}, rdata0);
        end
        model_last = 1'b1;
        tick();
    endtask

    task automatic test_contention();
        logic          w;
        logic [DW-1:0] exp_d, obs_d;
        req0 = 1'b1; we0 = 1'b0; be0 = '1; addr0 = 32'h30;
        req1 = 1'b1; we1 = 1'b0; be1 = '1; addr1 = 32'h8; lock1 = 1'b0;
        w = ~model_last;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({gnt1, gnt0} !== (w ? 2'b10 : 2'b01) || mem_addr !== (w ? 32'h8 : 32'h30)) begin
                errors++;
                $display("[TB] FAIL contention_gnt%0d: got %b/%h expected winner %0d", k, {gnt1, gnt0}, mem_addr, w);
            end
            if (k >= 2) begin
                if (w) req1 = 1'b0; else req0 = 1'b0;
            end
            tick();
            exp_d = w ? ref_mem[2] : ref_mem[12];
            obs_d = w ? rdata1 : rdata0;
            checks++;
            if ({gnt1, gnt0, rvalid1, rvalid0} !== (w ? 4'b0010 : 4'b0001) || obs_d !== exp_d) begin
                errors++;
                $display("[TB] FAIL contention_resp%0d: got %b/%h expected winner %0d data %h", k,
                         {gnt1, gnt0, rvalid1, rvalid0}, obs_d, w, exp_d);
            end
            model_last = w;
            w = ~w;
        end
        tick();
    endtask

    task automatic test_lock_burst();
        logic [DW-1:0] d [3];
        for (int k = 0; k < 3; k++) d[k] = $urandom;
        req1 = 1'b1; we1 = 1'b1; be1 = '1; addr1 = 32'h50; wdata1 = d[0]; lock1 = 1'b1;
        tick();
        checks++;
        if ({gnt1, gnt0} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL lock_gnt0: got %b expected 10", {gnt1, gnt0});
        end
        ref_write(32'h50, '1, d[0]);
        req0 = 1'b1; we0 = 1'b0; be0 = '1; addr0 = 32'h54;
        addr1 = 32'h54; wdata1 = d[1];
        for (int k = 1; k < 3; k++) begin
            tick();
            checks++;
            if ({rvalid1, gnt0} !== 2'b10) begin
                errors++;
                $display("[TB] FAIL lock_resp%0d: got %b expected 10", k, {rvalid1, gnt0});
            end
            tick();
            checks++;
            if ({gnt1, gnt0} !== 2'b10 || mem_addr !== 32'h50 + 32'(4 * k) || mem_wdata !== d[k]) begin
                errors++;
                $display("[TB] FAIL lock_gnt%0d: got %b/%h/%h expected 10/%h/%h", k, {gnt1, gnt0}, mem_addr,
                         mem_wdata, 32'h50 + 32'(4 * k), d[k]);
            end
            ref_write(32'h50 + 32'(4 * k), '1, d[k]);
            if (k == 1) begin
                addr1 = 32'h58; wdata1 = d[2]; lock1 = 1'b0;
            end else begin
                req1 = 1'b0;
            end
        end
        tick();
        checks++;
        if ({rvalid1, gnt0} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL lock_last_resp: got %b expected 10", {rvalid1, gnt0});
        end
        tick();
        checks++;
        if ({gnt1, gnt0} !== 2'b01 || mem_addr !== 32'h54) begin
            errors++;
            $display("[TB] FAIL lock_release_gnt: got %b/%h expected 01/54", {gnt1, gnt0}, mem_addr);
        end
        req0 = 1'b0;
        tick();
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== d[1]) begin
            errors++;
            $display("[TB] FAIL lock_readback: got %b/%h expected 1/%h", rvalid0, rdata0, d[1]);
        end
        model_last = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        req0 = 1'b1; we0 = 1'b0; be0 = '1; addr0 = 32'h10;
        req1 = 1'b1; we1 = 1'b0; be1 = '1; addr1 = 32'h14; lock1 = 1'b0;
        tick();
        checks++;
        if ({gnt1, gnt0, mem_en} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL midreset_pre: got %b expected 101", {gnt1, gnt0, mem_en});
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, mem_be, mem_addr, mem_wdata, rdata0, rdata1, lock_err} !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_async: got %h expected 0",
                     {gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, mem_be, mem_addr, mem_wdata, rdata0, rdata1});
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        ref_reset();
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({rvalid0, rvalid1, gnt0, gnt1} !== 4'b0) begin
                errors++;
                $display("[TB] FAIL midreset_quiet%0d: got %b expected 0", k, {rvalid0, rvalid1, gnt0, gnt1});
            end
        end
        req0 = 1'b1; req1 = 1'b1;
        tick();
        checks++;
        if ({gnt1, gnt0} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL midreset_first_gnt: got %b expected 01", {gnt1, gnt0});
        end
        req0 = 1'b0;
        tick();
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL midreset_resp0: got %b/%h expected 1/deadbeef", rvalid0, rdata0);
        end
        tick();
        checks++;
        if ({gnt1, gnt0} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL midreset_gnt1: got %b expected 10", {gnt1, gnt0});
        end
        req1 = 1'b0;
        tick();
        checks++;
        if (rvalid1 !== 1'b1 || rdata1 !== ref_mem[5]) begin
            errors++;
            $display("[TB] FAIL midreset_resp1: got %b/%h expected 1/%h", rvalid1, rdata1, ref_mem[5]);
        end
        model_last = 1'b1;
        tick();
    endtask

    task automatic test_random(input int n_cycles);
        logic          pend [2];
        logic          c_we [2];
        logic [BW-1:0] c_be [2];
        logic [AW-1:0] c_addr [2];
        logic [DW-1:0] c_wdata [2];
        logic          c_lock;
        logic          acc_v, acc_w, acc_rd, rsp_v, rsp_w, rsp_rd;
        logic [DW-1:0] acc_data, rsp_data, obs;
        logic [DW-1:0] hold [2];
        logic          known [2];
        logic          lockable, win, any;
`ifdef DMEM_ARB_LOCK_TIMEOUT_EN
        lockable = 1'b0;
`else
        lockable = 1'b1;
`endif
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; known[i] = 1'b0; hold[i] = '0;
            c_we[i] = 1'b0; c_be[i] = '0; c_addr[i] = '0; c_wdata[i] = '0;
        end
        c_lock = 1'b0;
        acc_v = 1'b0; acc_w = 1'b0; acc_rd = 1'b0; acc_data = '0;
        rsp_v = 1'b0; rsp_w = 1'b0; rsp_rd = 1'b0; rsp_data = '0;
        for (int c = 0; c < n_cycles + 40; c++) begin
            tick();
            checks++;
            if ({gnt1, gnt0, mem_en} !== {acc_v & acc_w, acc_v & ~acc_w, acc_v}) begin
                errors++;
                $display("[TB] FAIL rand_gnt@%0d: got %b expected %b", c, {gnt1, gnt0, mem_en},
                         {acc_v & acc_w, acc_v & ~acc_w, acc_v});
            end
            if (acc_v) begin
                checks++;
                if ({mem_we, mem_be, mem_addr, mem_wdata} !== {c_we[acc_w], c_be[acc_w], c_addr[acc_w], c_wdata[acc_w]}) begin
                    errors++;
                    $display("[TB] FAIL rand_cmd@%0d: got %h expected %h", c, {mem_we, mem_be, mem_addr, mem_wdata},
                             {c_we[acc_w], c_be[acc_w], c_addr[acc_w], c_wdata[acc_w]});
                end
            end
            checks++;
            if ({rvalid1, rvalid0} !== {rsp_v & rsp_w, rsp_v & ~rsp_w}) begin
                errors++;
                $display("[TB] FAIL rand_rvalid@%0d: got %b expected %b", c, {rvalid1, rvalid0}, {rsp_v & rsp_w, rsp_v & ~rsp_w});
            end
            for (int i = 0; i < 2; i++) begin
                if (rsp_v && int'(rsp_w) == i) begin
                    known[i] = rsp_rd;
                    hold[i]  = rsp_data;
                end
                if (known[i]) begin
                    obs = (i == 1) ? rdata1 : rdata0;
                    checks++;
                    if (obs !== hold[i]) begin
                        errors++;
                        $display("[TB] FAIL rand_rdata%0d@%0d: got %h expected %h", i, c, obs, hold[i]);
                    end
                end
            end
            if (acc_v) pend[acc_w] = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && c < n_cycles && $urandom_range(0, 9) < 6) begin
                    pend[i]    = 1'b1;
                    c_we[i]    = 1'($urandom_range(0, 1));
                    c_be[i]    = BW'($urandom);
                    c_addr[i]  = $urandom;
                    c_wdata[i] = $urandom;
                    if (i == 1) c_lock = lockable && ($urandom_range(0, 3) == 0);
                end else if (!pend[i] && c >= n_cycles && i == 1 && model_lock) begin
                    pend[1]   = 1'b1;
                    c_we[1]   = 1'b0;
                    c_addr[1] = $urandom;
                    c_lock    = 1'b0;
                end
            end
            req0 = pend[0]; we0 = c_we[0]; be0 = c_be[0]; addr0 = c_addr[0]; wdata0 = c_wdata[0];
            req1 = pend[1]; we1 = c_we[1]; be1 = c_be[1]; addr1 = c_addr[1]; wdata1 = c_wdata[1];
            lock1 = c_lock;
            rsp_v = acc_v; rsp_w = acc_w; rsp_rd = acc_rd; rsp_data = acc_data;
            acc_v = 1'b0;
            if (!rsp_v) begin
                any = 1'b0; win = 1'b0;
                if (model_lock) begin
                    any = pend[1]; win = 1'b1;
                end else if (pend[0] && pend[1]) begin
                    any = 1'b1; win = ~model_last;
                end else if (pend[0] || pend[1]) begin
                    any = 1'b1; win = pend[1];
                end
                if (any) begin
                    acc_v      = 1'b1;
                    acc_w      = win;
                    model_last = win;
                    if (win) model_lock = c_lock;
                    acc_rd   = ~c_we[win];
                    acc_data = ref_mem[c_addr[win][7:2]];
                    if (c_we[win]) ref_write(c_addr[win], c_be[win], c_wdata[win]);
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
        tick();
        tick();
        checks++;
        if (lock_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rand_lock_err: got %b expected 0", lock_err);
        end
    endtask

`ifdef DMEM_ARB_LOCK_TIMEOUT_EN
    task automatic test_lock_timeout();
        logic seen_err, done;
        seen_err = 1'b0; done = 1'b0;
        req0 = 1'b1; we0 = 1'b0; be0 = '1; addr0 = 32'h40;
        req1 = 1'b1; we1 = 1'b0; be1 = '1; addr1 = 32'h44; lock1 = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            tick();
            if (lock_err === 1'b1) seen_err = 1'b1;
            if (seen_err && (gnt0 === 1'b1 || gnt1 === 1'b1)) begin
                done = 1'b1;
                checks++;
                if ({gnt1, gnt0} !== 2'b01) begin
                    errors++;
                    $display("[TB] FAIL timeout_next_gnt: got %b expected 01", {gnt1, gnt0});
                end
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL timeout_lock_err: got %b expected 1 within 200 cycles", lock_err);
        end
        req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
        repeat (6) tick();
        checks++;
        if (lock_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_sticky: got %b expected 1", lock_err);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (lock_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_clear: got %b expected 0", lock_err);
        end
        tick();
        reset = 1'b1;
        ref_reset();
        tick();
    endtask
`endif

    // Bound the whole run so a stuck DUT still ends with a report.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence.
    initial begin
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; lock1 = 1'b0;
        be0 = '0; be1 = '0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_lock_burst();
        test_reset_mid_access();
        test_random(300);
`ifdef DMEM_ARB_LOCK_TIMEOUT_EN
        test_lock_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
